knn_mem_sequencer: RTL and testbench

KNN_MEM_SEQUENCER -- requirements
Module: knn_mem_sequencer

---
 rtl/knn_mem_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 tb/tb_knn_mem_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/knn_mem_sequencer.sv
// ---------------------------------------------------------------------------
// knn_mem_sequencer
//
// Purpose:
//   Sequences memory traffic for a k-nearest-neighbour classifier. For every
//   input record of a job it reads the input feature vector. It then streams
//   the training table to a compute engine in batches of P lanes, waits for
//   the classifier result and writes that result back over the type word of
//   the input record.
//
//   Record layout in memory: one type word (class in the low TYPE_W bits)
//   followed by N_FEAT feature words. The record stride is
//   R = (N_FEAT+1)*ADDR_STEP. Input k lives at BASE_I_ADDR + k*R and training
//   record t lives at BASE_T_ADDR + t*R. Address arithmetic wraps silently
//   modulo 2^ADDR_W.
//
// Ports:
//   clk             clock
//   rst_n           synchronous active-low reset
//   start           one-cycle job request (only honoured in IDLE)
//   num_inputs      number of input records in the job
//   rd_en/rd_addr   one-cycle read strobe and address
//   rd_data         read data, valid RD_LAT cycles after rd_en
//   wr_en/wr_addr/wr_data  one-cycle result write
//   input_data      current input vector, feature f at [W*(f+1)-1 -: W]
//   training_data   P lanes of N_FEAT features, lane p in slice p
//   training_type   class of each lane
//   lane_valid      lane holds a real training record
//   batch_valid     batch presented, held stable until batch_ready
//   batch_ready     compute engine accepts the batch
//   last_batch      qualifies batch_valid: final batch for this input
//   inferred_type   classifier result
//   inference_done  one-cycle result strobe (only honoured in WAIT_INF)
//   busy            high whenever the sequencer is not idle
//   done            one-cycle job completion pulse
// ---------------------------------------------------------------------------
module knn_mem_sequencer #(
  parameter int W           = 16,
  parameter int N_FEAT      = 4,
  parameter int L           = 8,
  parameter int P           = 2,
  parameter int TYPE_W      = 4,
  parameter int ADDR_W      = 16,
  parameter int ADDR_STEP   = 1,
  parameter int BASE_T_ADDR = 0,
  parameter int BASE_I_ADDR = 256,
  parameter int RD_LAT      = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [15:0]                num_inputs,
  output logic                       rd_en,
  output logic [ADDR_W-1:0]          rd_addr,
  input  logic [W-1:0]               rd_data,
  output logic                       wr_en,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [W-1:0]               wr_data,
  output logic [W*N_FEAT-1:0]        input_data,
  output logic [P*W*N_FEAT-1:0]      training_data,
  output logic [P*TYPE_W-1:0]        training_type,
  output logic [P-1:0]               lane_valid,
  output logic                       batch_valid,
  input  logic                       batch_ready,
  output logic                       last_batch,
  input  logic [TYPE_W-1:0]          inferred_type,
  input  logic                       inference_done,
  output logic                       busy,
  output logic                       done
);

  // Number of batches needed to cover the training table.
  localparam int NB     = (L + P - 1) / P;
  localparam int LANE_W = $clog2(P + 1);      // lane index, counts 0..P
  localparam int WORD_W = $clog2(N_FEAT + 1); // word index within a record
  localparam int T_W    = $clog2(L + P + 1);  // training index, may run past L
  localparam int B_W    = $clog2(NB + 1);
  localparam int LAT_W  = $clog2(RD_LAT + 1);

  localparam logic [ADDR_W-1:0] STEP_A   = ADDR_W'(ADDR_STEP);
  localparam logic [ADDR_W-1:0] REC_A    = ADDR_W'((N_FEAT + 1) * ADDR_STEP);
  localparam logic [ADDR_W-1:0] BASE_T_A = ADDR_W'(BASE_T_ADDR);
  localparam logic [ADDR_W-1:0] BASE_I_A = ADDR_W'(BASE_I_ADDR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_IN,
    S_RD_TR,
    S_PRESENT,
    S_WAIT_INF,
    S_WRITE,
    S_FINISH
  } state_t;

  state_t                  r_state;
  logic [15:0]             r_k;          // current input index
  logic [15:0]             r_num;        // job length captured at start
  logic [B_W-1:0]          r_b;          // current batch index
  logic [T_W-1:0]          r_t;          // training record for the current lane
  logic [LANE_W-1:0]       r_lane;       // lane being filled
  logic [WORD_W-1:0]       r_word;       // word within the record being read
  logic [ADDR_W-1:0]       r_ptr;        // next read address
  logic [ADDR_W-1:0]       r_in_base;    // base address of input k
  logic                    r_pend;       // a read is in flight
  logic [LAT_W-1:0]        r_lat;        // edges left until rd_data is captured

  logic                    r_rd_en;
  logic [ADDR_W-1:0]       r_rd_addr;
  logic                    r_wr_en;
  logic [ADDR_W-1:0]       r_wr_addr;
  logic [W-1:0]            r_wr_data;
  logic [W*N_FEAT-1:0]     r_input_data;
  logic [P*W*N_FEAT-1:0]   r_training_data;
  logic [P*TYPE_W-1:0]     r_training_type;
  logic [P-1:0]            r_lane_valid;
  logic                    r_batch_valid;
  logic                    r_last_batch;
  logic                    r_done;

  logic [16:0]             w_k_next;
  logic                    w_more_inputs;

  assign w_k_next      = {1'b0, r_k} + 17'd1;
  assign w_more_inputs = (w_k_next < {1'b0, r_num});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_k             <= '0;
      r_num           <= '0;
      r_b             <= '0;
      r_t             <= '0;
      r_lane          <= '0;
      r_word          <= '0;
      r_ptr           <= '0;
      r_in_base       <= '0;
      r_pend          <= 1'b0;
      r_lat           <= '0;
      r_rd_en         <= 1'b0;
      r_rd_addr       <= '0;
      r_wr_en         <= 1'b0;
      r_wr_addr       <= '0;
      r_wr_data       <= '0;
      r_input_data    <= '0;
      r_training_data <= '0;
      r_training_type <= '0;
      r_lane_valid    <= '0;
      r_batch_valid   <= 1'b0;
      r_last_batch    <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      r_rd_en <= 1'b0;
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_num     <= num_inputs;
            r_k       <= '0;
            r_in_base <= BASE_I_A;
            if (num_inputs == 16'd0) begin
              r_state <= S_FINISH;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RD_IN;
              r_word  <= '0;
              // The type word of the input is skipped.
              r_ptr   <= BASE_I_A + STEP_A;
            end
          end
        end

        S_RD_IN: begin
          if (r_pend) begin
            // r_lat reaches 0 on the edge where rd_data is valid.
            if (r_lat == '0) begin
              r_pend <= 1'b0;
              for (int f = 0; f < N_FEAT; f++) begin
                if (r_word == WORD_W'(f)) begin
                  r_input_data[f*W +: W] <= rd_data;
                end
              end
              if (r_word == WORD_W'(N_FEAT - 1)) begin
                r_state <= S_RD_TR;
                r_b     <= '0;
                r_t     <= '0;
                r_lane  <= '0;
                r_word  <= '0;
                r_ptr   <= BASE_T_A;
              end else begin
                r_word <= r_word + WORD_W'(1);
              end
            end else begin
              r_lat <= r_lat - LAT_W'(1);
            end
          end else begin
            r_rd_en   <= 1'b1;
            r_rd_addr <= r_ptr;
            r_ptr     <= r_ptr + STEP_A;
            r_pend    <= 1'b1;
            r_lat     <= LAT_W'(RD_LAT);
          end
        end

        S_RD_TR: begin
          if (r_pend) begin
            if (r_lat == '0) begin
              r_pend <= 1'b0;
              // Word 0 of a record is the type, words 1..N_FEAT the features.
              for (int p = 0; p < P; p++) begin
                if (r_lane == LANE_W'(p)) begin
                  if (r_word == '0) begin
                    r_training_type[p*TYPE_W +: TYPE_W] <= rd_data[TYPE_W-1:0];
                  end
                  for (int f = 0; f < N_FEAT; f++) begin
                    if (r_word == WORD_W'(f + 1)) begin
                      r_training_data[(p*N_FEAT + f)*W +: W] <= rd_data;
                    end
                  end
                end
              end
              if (r_word == WORD_W'(N_FEAT)) begin
                r_word <= '0;
                r_lane <= r_lane + LANE_W'(1);
                r_t    <= r_t + T_W'(1);
              end else begin
                r_word <= r_word + WORD_W'(1);
              end
            end else begin
              r_lat <= r_lat - LAT_W'(1);
            end
          end else if (r_lane == LANE_W'(P)) begin
            r_state       <= S_PRESENT;
            r_batch_valid <= 1'b1;
            r_last_batch  <= (r_b == B_W'(NB - 1));
          end else if (r_t >= T_W'(L)) begin
            // Past the end of the table: lane is padding, not read.
            for (int p = 0; p < P; p++) begin
              if (r_lane == LANE_W'(p)) begin
                r_training_type[p*TYPE_W +: TYPE_W]   <= '0;
                r_training_data[p*N_FEAT*W +: N_FEAT*W] <= '0;
                r_lane_valid[p]                       <= 1'b0;
              end
            end
            r_lane <= r_lane + LANE_W'(1);
            r_t    <= r_t + T_W'(1);
          end else begin
            if (r_word == '0) begin
              for (int p = 0; p < P; p++) begin
                if (r_lane == LANE_W'(p)) begin
                  r_lane_valid[p] <= 1'b1;
                end
              end
            end
            r_rd_en   <= 1'b1;
            r_rd_addr <= r_ptr;
            r_ptr     <= r_ptr + STEP_A;
            r_pend    <= 1'b1;
            r_lat     <= LAT_W'(RD_LAT);
          end
        end

        S_PRESENT: begin
          // All batch outputs are registers and untouched here, so they stay
          // stable for as long as the engine stalls.
          if (batch_ready) begin
            r_batch_valid <= 1'b0;
            r_last_batch  <= 1'b0;
            if (r_last_batch) begin
              r_state <= S_WAIT_INF;
            end else begin
              // The training pointer simply continues: records are contiguous.
              r_state <= S_RD_TR;
              r_b     <= r_b + B_W'(1);
              r_lane  <= '0;
              r_word  <= '0;
            end
          end
        end

        S_WAIT_INF: begin
          if (inference_done) begin
            r_state   <= S_WRITE;
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_in_base;
            r_wr_data <= W'(inferred_type);
          end
        end

        S_WRITE: begin
          if (w_more_inputs) begin
            r_state   <= S_RD_IN;
            r_k       <= r_k + 16'd1;
            r_in_base <= r_in_base + REC_A;
            r_ptr     <= r_in_base + REC_A + STEP_A;
            r_word    <= '0;
          end else begin
            r_state <= S_FINISH;
            r_done  <= 1'b1;
          end
        end

        S_FINISH: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rd_en         = r_rd_en;
  assign rd_addr       = r_rd_addr;
  assign wr_en         = r_wr_en;
  assign wr_addr       = r_wr_addr;
  assign wr_data       = r_wr_data;
  assign input_data    = r_input_data;
  assign training_data = r_training_data;
  assign training_type = r_training_type;
  assign lane_valid    = r_lane_valid;
  assign batch_valid   = r_batch_valid;
  assign last_batch    = r_last_batch;
  assign busy          = (r_state != S_IDLE);
  assign done          = r_done;

endmodule

// File: tb/tb_knn_mem_sequencer.sv
// ---------------------------------------------------------------------------
// tb_knn_mem_sequencer
//
// Purpose:
//   Self-checking bench for knn_mem_sequencer with N_FEAT=4, L=5, P=2,
//   RD_LAT=2. A memory model with random contents answers reads; a reference
//   model builds, per job, the expected read-address sequence, the expected
//   batches and the expected result writes directly from the record layout.
//   A negedge monitor compares the DUT against those queues.
// ---------------------------------------------------------------------------
module tb_knn_mem_sequencer;

  localparam int W    = 16;
  localparam int NF   = 4;
  localparam int L    = 5;
  localparam int P    = 2;
  localparam int TW   = 4;
  localparam int AW   = 16;
  localparam int STEP = 1;
  localparam int BT   = 0;
  localparam int BI   = 256;
  localparam int RL   = 2;
  localparam int R    = (NF + 1) * STEP;
  localparam int NB   = (L + P - 1) / P;

  typedef struct packed {
    logic [W*NF-1:0]   vin;
    logic [P*W*NF-1:0] td;
    logic [P*TW-1:0]   tt;
    logic [P-1:0]      lv;
    logic              last;
  } batch_t;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [15:0]       num_inputs;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic [W-1:0]      rd_data;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [W-1:0]      wr_data;
  logic [W*NF-1:0]   input_data;
  logic [P*W*NF-1:0] training_data;
  logic [P*TW-1:0]   training_type;
  logic [P-1:0]      lane_valid;
  logic              batch_valid;
  logic              batch_ready;
  logic              last_batch;
  logic [TW-1:0]     inferred_type;
  logic              inference_done;
  logic              busy;
  logic              done;

  knn_mem_sequencer #(
    .W(W), .N_FEAT(NF), .L(L), .P(P), .TYPE_W(TW), .ADDR_W(AW),
    .ADDR_STEP(STEP), .BASE_T_ADDR(BT), .BASE_I_ADDR(BI), .RD_LAT(RL)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_inputs(num_inputs),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .input_data(input_data), .training_data(training_data),
    .training_type(training_type), .lane_valid(lane_valid),
    .batch_valid(batch_valid), .batch_ready(batch_ready),
    .last_batch(last_batch), .inferred_type(inferred_type),
    .inference_done(inference_done), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [W-1:0]  mem [0:65535];
  logic          pipe_v [RL];
  logic [AW-1:0] pipe_a [RL];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < RL; i++) pipe_v[i] <= 1'b0;
    end else begin
      pipe_v[0] <= rd_en;
      pipe_a[0] <= rd_addr;
      for (int i = 1; i < RL; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_a[i] <= pipe_a[i-1];
      end
    end
  end

  // Garbage outside the valid window exposes a mistimed capture.
  assign rd_data = pipe_v[RL-1] ? mem[pipe_a[RL-1]] : W'(16'hBEEF);

  // ---------------- scoreboard ----------------
  int            n_checks = 0;
  int            n_pass   = 0;
  logic [AW-1:0] exp_rd [$];
  batch_t        exp_b  [$];
  logic [AW-1:0] exp_wa [$];
  logic [W-1:0]  exp_wd [$];
  logic [TW-1:0] itype [0:15];

  bit mon_en      = 1'b0;
  int cyc         = 0;
  int last_rd_cyc = -1;
  int done_cnt    = 0;
  int done_cyc    = -1;
  int start_cyc   = -1;
  int xfer_last   = 0;
  bit saw_tr_read = 1'b0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 65536; i++) mem[i] = W'($urandom);
  endtask

  // Reference model: expected traffic for a job of n inputs, straight from
  // the record layout.
  task automatic build_expect(input int n);
    logic [AW-1:0]   a;
    logic [AW-1:0]   ib;
    logic [AW-1:0]   base;
    logic [W-1:0]    word;
    logic [W*NF-1:0] vec;
    batch_t          bt;
    int              t;
    exp_rd.delete(); exp_b.delete(); exp_wa.delete(); exp_wd.delete();
    for (int k = 0; k < n; k++) begin
      itype[k] = TW'($urandom);
      ib = AW'(BI + k * R);
      for (int f = 0; f < NF; f++) begin
        a = AW'(ib + STEP * (f + 1));
        exp_rd.push_back(a);
        vec[f*W +: W] = mem[a];
      end
      for (int b = 0; b < NB; b++) begin
        bt = '0;
        bt.vin  = vec;
        bt.last = (b == NB - 1);
        for (int p = 0; p < P; p++) begin
          t = b * P + p;
          if (t < L) begin
            base = AW'(BT + t * R);
            for (int w = 0; w <= NF; w++) exp_rd.push_back(AW'(base + w * STEP));
            word = mem[base];
            bt.tt[p*TW +: TW] = word[TW-1:0];
            for (int f = 0; f < NF; f++) bt.td[(p*NF + f)*W +: W] = mem[AW'(base + (f + 1) * STEP)];
            bt.lv[p] = 1'b1;
          end
        end
        exp_b.push_back(bt);
      end
      exp_wa.push_back(ib);
      exp_wd.push_back(W'(itype[k]));
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (start && start_cyc < 0) start_cyc = cyc;
      if (rd_en) begin
        if (exp_rd.size() == 0) chk("rd_unexpected", rd_en, 0);
        else chk("rd_addr", rd_addr, exp_rd.pop_front());
        if (last_rd_cyc >= 0) chk("rd_spacing", (cyc - last_rd_cyc) >= RL + 1, 1);
        last_rd_cyc = cyc;
        if (rd_addr < AW'(BI)) saw_tr_read = 1'b1;
      end
      if (batch_valid) begin
        chk("rd_during_present", rd_en, 0);
        if (exp_b.size() == 0) begin
          chk("batch_unexpected", batch_valid, 0);
        end else begin
          chk("batch_input_data", input_data, exp_b[0].vin);
          chk("batch_training_data", training_data, exp_b[0].td);
          chk("batch_training_type", training_type, exp_b[0].tt);
          chk("batch_lane_valid", lane_valid, exp_b[0].lv);
          chk("batch_last", last_batch, exp_b[0].last);
          if (batch_ready) begin
            if (exp_b[0].last) xfer_last++;
            void'(exp_b.pop_front());
          end
        end
      end else begin
        chk("last_without_valid", last_batch, 0);
      end
      if (wr_en) begin
        if (exp_wa.size() == 0) begin
          chk("wr_unexpected", wr_en, 0);
        end else begin
          chk("wr_addr", wr_addr, exp_wa.pop_front());
          chk("wr_data", wr_data, exp_wd.pop_front());
        end
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
    end
  end

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_rd_en"}, rd_en, 0);
    chk({pfx, "_rd_addr"}, rd_addr, 0);
    chk({pfx, "_wr_en"}, wr_en, 0);
    chk({pfx, "_wr_addr"}, wr_addr, 0);
    chk({pfx, "_wr_data"}, wr_data, 0);
    chk({pfx, "_input_data"}, input_data, 0);
    chk({pfx, "_training_data"}, training_data, 0);
    chk({pfx, "_training_type"}, training_type, 0);
    chk({pfx, "_lane_valid"}, lane_valid, 0);
    chk({pfx, "_batch_valid"}, batch_valid, 0);
    chk({pfx, "_last_batch"}, last_batch, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, done, 0);
  endtask

  // mode 0: batch_ready tied 1; mode 1: random; mode 2: first batch stalled
  // for 10 cycles. disturb pulses start and inference_done during RD_TR.
  task automatic run_job(input int n, input int mode, input bit disturb);
    int d;
    int inf_sent;
    int hold;
    bit dist_done;
    build_expect(n);
    done_cnt = 0; done_cyc = -1; start_cyc = -1; xfer_last = 0;
    saw_tr_read = 1'b0; last_rd_cyc = -1;
    inf_sent = 0; hold = 0; dist_done = 1'b0; d = $urandom_range(0, 3);
    @(posedge clk); #2;
    num_inputs = 16'(n);
    start = 1'b1;
    for (int c = 0; c < 3000 && done_cnt == 0; c++) begin
      @(posedge clk); #2;
      start = 1'b0;
      inference_done = 1'b0;
      case (mode)
        0: batch_ready = 1'b1;
        1: batch_ready = 1'($urandom_range(0, 1));
        default: begin
          if (batch_valid && hold < 10) begin
            batch_ready = 1'b0;
            hold++;
          end else begin
            batch_ready = 1'b1;
          end
        end
      endcase
      if (xfer_last > inf_sent) begin
        if (d == 0) begin
          inference_done = 1'b1;
          inferred_type  = itype[inf_sent];
          inf_sent++;
          d = $urandom_range(0, 3);
        end else begin
          d--;
        end
      end else if (disturb && saw_tr_read && !dist_done) begin
        start          = 1'b1;
        inference_done = 1'b1;
        inferred_type  = ~itype[0];
        dist_done      = 1'b1;
      end
    end
    @(posedge clk); #2;
    start = 1'b0; inference_done = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("done_pulses", done_cnt, 1);
    if (n == 0) chk("done_latency", done_cyc - start_cyc, 1);
    if (disturb) chk("disturb_applied", dist_done, 1);
    chk("rd_remaining", exp_rd.size(), 0);
    chk("batch_remaining", exp_b.size(), 0);
    chk("wr_remaining", exp_wa.size(), 0);
    chk("busy_after_job", busy, 0);
    $display("job inputs=%0d mode=%0d disturb=%0d checks=%0d passed=%0d", n, mode, disturb, n_checks, n_pass);
  endtask

  task automatic abort_test();
    build_expect(1);
    saw_tr_read = 1'b0; last_rd_cyc = -1; done_cnt = 0;
    @(posedge clk); #2;
    num_inputs  = 16'd1;
    start       = 1'b1;
    batch_ready = 1'b1;
    for (int c = 0; c < 200 && !saw_tr_read; c++) begin
      @(posedge clk); #2;
      start = 1'b0;
    end
    chk("abort_reached_rd_tr", saw_tr_read, 1);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("abort");
    @(posedge clk); #2;
    rst_n = 1'b1;
    exp_rd.delete(); exp_b.delete(); exp_wa.delete(); exp_wd.delete();
    done_cnt = 0; last_rd_cyc = -1;
    mon_en = 1'b1;
    repeat (12) @(posedge clk);
    #2;
    chk("abort_no_done", done_cnt, 0);
    chk("abort_idle", busy, 0);
    $display("abort during RD_TR checks=%0d passed=%0d", n_checks, n_pass);
  endtask

  initial begin
    rst_n          = 1'b0;
    start          = 1'b0;
    num_inputs     = '0;
    batch_ready    = 1'b0;
    inferred_type  = '0;
    inference_done = 1'b0;
    fill_mem();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #2;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    run_job(1, 0, 1'b0);   // single input, engine always ready
    run_job(0, 0, 1'b0);   // empty job
    run_job(1, 2, 1'b0);   // stalled batch
    run_job(2, 1, 1'b0);   // two inputs, random back-pressure
    abort_test();
    run_job(1, 0, 1'b0);   // clean job after abort
    run_job(1, 0, 1'b1);   // stray start / inference_done in RD_TR
    for (int i = 0; i < 3; i++) begin
      fill_mem();
      run_job($urandom_range(1, 3), 1, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
